// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Results are computed at the start edge and committed after a fixed busy window.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               load_res, commit;
    logic [31:0]        res_hi_p0, res_lo_p0;
    logic               res_wr_p0;
    logic [64:0]        calc;

    // Returns {write_enable, hi, lo}; a zero divisor suppresses the write.
    function automatic logic [64:0] md_calc(input logic [1:0] fn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic [64:0]        r;
        sa = a;
        sb = b;
        sp = '0;
        up = '0;
        r  = '0;
        case (fn)
            2'd0: begin
                sp = 64'(sa) * 64'(sb);
                r  = {1'b1, sp};
            end
            2'd1: begin
                up = 64'(a) * 64'(b);
                r  = {1'b1, up};
            end
            2'd2: begin
                if (b == 32'd0)
                    r = '0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {1'b1, 32'h0, 32'h8000_0000};
                else
                    r = {1'b1, 32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0)
                    r = '0;
                else
                    r = {1'b1, a % b, a / b};
            end
        endcase
        return r;
    endfunction

    assign calc     = md_calc(op[1:0], A, B);
    assign busy     = (state == BUSY);
    assign stall_md = md_use_D & (busy | start);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_res  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !op[2]) begin
                    state_nxt = BUSY;
                    cnt_nxt   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    load_res  = 1'b1;
                end
            end
            default: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            res_hi_p0 <= '0;
            res_lo_p0 <= '0;
            res_wr_p0 <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_res) begin
                res_wr_p0 <= calc[64];
                res_hi_p0 <= calc[63:32];
                res_lo_p0 <= calc[31:0];
            end
            // Commit only happens in BUSY and MTHI/MTLO only in IDLE, so they never collide
            if (commit) begin
                if (res_wr_p0) begin
                    HI <= res_hi_p0;
                    LO <= res_lo_p0;
                end
            end else if (state == IDLE && start && op == 3'd4) begin
                HI <= A;
            end else if (state == IDLE && start && op == 3'd5) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: latency, arithmetic results, MTHI/MTLO, stall and abort.
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        md_use_D = 1'b0;
    logic        busy, stall_md;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_errors = 0;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .md_use_D(md_use_D), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0; op = 3'd7;
    endtask

    // Run one op; inj >= 0 injects a MULT start during that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input int inj,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, a, b);
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, busy, 1);
            if (i == inj) begin
                start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd7;
            end
            step();
            start = 1'b0; op = 3'd7;
        end
        chk({tag, " busy_fall"}, busy, 0);
        chk({tag, " HI"}, HI, exp_hi);
        chk({tag, " LO"}, LO, exp_lo);
        step();
        chk({tag, " idle"}, busy, 0);
        chk({tag, " HI_hold"}, HI, exp_hi);
        chk({tag, " LO_hold"}, LO, exp_lo);
    endtask

    initial begin
        step();
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst HI", HI, 0);
        chk("rst LO", LO, 0);

        // Abort a DIV mid-flight with reset
        issue(3'd4, 32'h0000_AAAA, 32'd0);
        chk("mthi pre", HI, 32'h0000_AAAA);
        issue(3'd2, 32'd100, 32'd7);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort HI", HI, 0);
        chk("abort LO", LO, 0);
        repeat (12) step();
        chk("abort HI late", HI, 0);
        chk("abort LO late", LO, 0);

        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, -1, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, -1, 32'd2, 32'd14);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, -1, 32'h0, 32'h8000_0000);

        issue(3'd4, 32'h0000_1234, 32'hDEAD_BEEF);
        chk("mthi busy", busy, 0);
        chk("mthi HI", HI, 32'h1234);
        chk("mthi LO", LO, 32'h8000_0000);
        issue(3'd5, 32'h0000_5678, 32'd0);
        chk("mtlo busy", busy, 0);
        chk("mtlo HI", HI, 32'h1234);
        chk("mtlo LO", LO, 32'h5678);
        issue(3'd6, 32'hFFFF_FFFF, 32'd1);
        chk("nop busy", busy, 0);
        chk("nop HI", HI, 32'h1234);
        chk("nop LO", LO, 32'h5678);
        run_op("div0", 3'd2, 32'd55, 32'd0, 10, -1, 32'h1234, 32'h5678);
        run_op("divu0", 3'd3, 32'd55, 32'd0, 10, -1, 32'h1234, 32'h5678);

        // Stall: start cycle plus the busy window
        md_use_D = 1'b1;
        chk("stall idle", stall_md, 0);
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        #1;
        chk("stall start", stall_md, 1);
        step();
        start = 1'b0; op = 3'd7;
        for (int i = 0; i < 5; i++) begin
            chk("stall busy", stall_md, 1);
            step();
        end
        chk("stall after", stall_md, 0);
        chk("stall LO", LO, 32'd15);
        md_use_D = 1'b0;
        start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd2;
        #1;
        chk("nostall start", stall_md, 0);
        step();
        start = 1'b0; op = 3'd7;
        for (int i = 0; i < 5; i++) begin
            chk("nostall busy", stall_md, 0);
            step();
        end
        chk("nostall LO", LO, 32'd4);

        // Starts while busy, including the commit edge, must be ignored
        run_op("inject_mid", 3'd0, 32'd3, 32'd5, 5, 2, 32'd0, 32'd15);
        run_op("inject_last", 3'd3, 32'd100, 32'd9, 10, 9, 32'd1, 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
